// File: rtl/pmod_pkg.sv
// Shared definitions for the PMod button reader: channel count, event
// word layout and the default debounce window.
package pmod_pkg;

  localparam int PMOD_W            = 8;
  localparam int EVT_TYPE_BIT      = 3;
  localparam int EVT_IDX_MSB       = 2;
  localparam int EVT_W             = EVT_TYPE_BIT + 1;
  localparam logic EVT_PRESS       = 1'b1;
  localparam logic EVT_RELEASE     = 1'b0;
  localparam int DB_CYCLES_DEFAULT = 120000;

  typedef struct packed {
    logic                 kind;
    logic [EVT_IDX_MSB:0] idx;
  } evt_t;

  function automatic evt_t make_evt(input logic kind, input int idx);
    evt_t e;
    e.kind = kind;
    e.idx  = idx[EVT_IDX_MSB:0];
    return e;
  endfunction

endpackage

// File: rtl/pmod_btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and single-cycle rise/fall pulses.
module pmod_btn_debounce
  import pmod_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // The level only flips after DB_CYCLES consecutive mismatching samples;
  // any matching sample restarts the count, which swallows contact bounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pmod_btn_reader.sv
// Eight debounced PMod buttons with edge pulses and a one-entry press/release
// event register behind a valid/ready handshake, plus a sticky overflow flag.
module pmod_btn_reader
  import pmod_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PMOD_W-1:0] BTN,
  output logic [PMOD_W-1:0] STATE,
  output logic [PMOD_W-1:0] PRESS,
  output logic [PMOD_W-1:0] RELEASE,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [EVT_W-1:0]  EVT_DATA,
  output logic              EVT_OVF
);

  logic [PMOD_W-1:0] pend_press;
  logic [PMOD_W-1:0] pend_rel;
  logic [PMOD_W-1:0] req_press;
  logic [PMOD_W-1:0] req_rel;
  logic [PMOD_W-1:0] load_press;
  logic [PMOD_W-1:0] load_rel;
  logic              do_load;
  logic              sel_valid;
  evt_t              sel_evt;

  for (genvar i = 0; i < PMOD_W; i++) begin : g_chan
    pmod_btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (CLK),
      .rst  (RST),
      .btn  (BTN[i]),
      .level(STATE[i]),
      .rise (PRESS[i]),
      .fall (RELEASE[i])
    );
  end

  // Fresh pulses join the pending set so an edge can reach the event
  // register on the very next cycle without first parking in a flag.
  assign req_press = pend_press | PRESS;
  assign req_rel   = pend_rel   | RELEASE;
  assign do_load   = ~EVT_VALID | EVT_READY;

  // Descending scan leaves the lowest channel selected, press over release.
  always_comb begin
    sel_valid  = 1'b0;
    sel_evt    = '0;
    load_press = '0;
    load_rel   = '0;
    for (int i = PMOD_W - 1; i >= 0; i--) begin
      if (req_rel[i]) begin
        sel_valid = 1'b1;
        sel_evt   = make_evt(EVT_RELEASE, i);
      end
      if (req_press[i]) begin
        sel_valid = 1'b1;
        sel_evt   = make_evt(EVT_PRESS, i);
      end
    end
    if (sel_valid && do_load) begin
      if (sel_evt.kind == EVT_PRESS) load_press[sel_evt.idx] = 1'b1;
      else                           load_rel[sel_evt.idx]   = 1'b1;
    end
  end

  // A new edge on a flag that is loaded this cycle stays pending; one that
  // lands on a flag still waiting is lost and marks the overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_press <= '0;
      pend_rel   <= '0;
      EVT_VALID  <= 1'b0;
      EVT_DATA   <= '0;
      EVT_OVF    <= 1'b0;
    end else begin
      pend_press <= (PRESS & (pend_press | ~load_press)) |
                    (~PRESS & pend_press & ~load_press);
      pend_rel   <= (RELEASE & (pend_rel | ~load_rel)) |
                    (~RELEASE & pend_rel & ~load_rel);
      if (|((PRESS & pend_press & ~load_press) |
            (RELEASE & pend_rel & ~load_rel)))
        EVT_OVF <= 1'b1;
      if (do_load) begin
        EVT_VALID <= sel_valid;
        if (sel_valid) EVT_DATA <= sel_evt;
      end
    end
  end

endmodule
